// File: rtl/bcd_digit_scanner.sv
// ============================================================================
// bcd_digit_scanner
// ----------------------------------------------------------------------------
// Time-multiplexed driver for a 4-digit common-anode BCD display.
//
// A prescaler divides the clock into digit slots of SCAN_DIV cycles each.
// Every slot selects one of four digits (digit0 first) and, after DEAD_CYC
// blanking cycles at the start of the slot, drives that digit's active-low
// enable. Four slots form one frame.
//
// New display values arrive over a valid/ready handshake into a shadow
// register. A captured value only becomes visible at the frame boundary, so
// a frame never mixes digits from two different values.
//
// Parameters
//   SCAN_DIV     clock cycles per digit slot (>= 2)
//   DEAD_CYC     blanking cycles at the start of each slot (0..SCAN_DIV-1)
//
// Optional feature (compile-time macro)
//   LEADING_ZERO_BLANK_EN  when defined, leading zero digits (above digit0)
//                          are output as nibble 4'hF so the decoder blanks
//                          them. Undefined by default: no blanking logic.
//
// Ports
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   load_valid   in   1   source offers a new 4-digit value
//   load_data    in   16  four BCD nibbles, [3:0] = digit0 ... [15:12] = digit3
//   load_ready   out  1   block can accept load_data
//   bcd          out  4   nibble for the active digit (to BCD-to-7-seg decoder)
//   digit_en     out  4   active-low one-hot digit enables, 4'b1111 = all off
//   frame_start  out  1   high during the first cycle of every frame
// ============================================================================
module bcd_digit_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEAD_CYC = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic [3:0]  bcd,
    output logic [3:0]  digit_en,
    output logic        frame_start
);

    // Prescaler width; SCAN_DIV of 2 still needs one bit.
    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] DEAD_LIM  = PW'(DEAD_CYC);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   disp_q, disp_d;
    logic [15:0]   shadow_q, shadow_d;
    logic          pending_q, pending_d;

    logic          slotTick;
    logic          wrapCycle;
    logic          transfer;
    logic          deadTime;
    logic [3:0]    activeNibble;

    // Last cycle of a slot; the last slot's last cycle is the frame boundary.
    assign slotTick  = (presc_q == PRESC_MAX);
    assign wrapCycle = slotTick && (idx_q == 2'd3);

    // Shadow is only writable while nothing is waiting to be committed, so a
    // held offer can never overwrite a value that has not been shown yet.
    assign transfer  = load_valid && !pending_q;

    // ------------------------------------------------------------------------
    // Next-state logic: slot/digit counters and the shadow-to-display commit.
    // A transfer and a commit can never coincide because a transfer needs
    // pending low and a commit needs it high; a transfer on the wrap cycle
    // therefore waits for the following frame boundary.
    // ------------------------------------------------------------------------
    always_comb begin
        presc_d   = slotTick ? '0 : presc_q + 1'b1;
        idx_d     = slotTick ? idx_q + 2'd1 : idx_q;
        disp_d    = disp_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;

        if (transfer) begin
            shadow_d  = load_data;
            pending_d = 1'b1;
        end

        if (wrapCycle && pending_q) begin
            disp_d    = shadow_q;
            pending_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // State registers. Reset drops any pending value: nothing is committed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= 2'd0;
            disp_q    <= 16'h0000;
            shadow_q  <= 16'h0000;
            pending_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
        end
    end

    // ------------------------------------------------------------------------
    // Blanking window at the start of each slot hides ghosting while the
    // digit lines switch. With no dead time the comparison would be constant.
    // ------------------------------------------------------------------------
    generate
        if (DEAD_CYC > 0) begin : gDead
            assign deadTime = (presc_q < DEAD_LIM);
        end else begin : gNoDead
            assign deadTime = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Digit selection from the committed display register.
    // ------------------------------------------------------------------------
    always_comb begin
        case (idx_q)
            2'd0:    activeNibble = disp_q[3:0];
            2'd1:    activeNibble = disp_q[7:4];
            2'd2:    activeNibble = disp_q[11:8];
            default: activeNibble = disp_q[15:12];
        endcase
    end

`ifdef LEADING_ZERO_BLANK_EN
    // ------------------------------------------------------------------------
    // Digit k (k>0) is a leading zero when it and every digit above it are
    // zero. Digit0 always shows, so a value of zero still displays "0".
    // ------------------------------------------------------------------------
    logic [3:0] lzBlank;

    always_comb begin
        lzBlank[0] = 1'b0;
        lzBlank[3] = (disp_q[15:12] == 4'h0);
        lzBlank[2] = lzBlank[3] && (disp_q[11:8] == 4'h0);
        lzBlank[1] = lzBlank[2] && (disp_q[7:4] == 4'h0);
    end

    assign bcd = lzBlank[idx_q] ? 4'hF : activeNibble;
`else
    assign bcd = activeNibble;
`endif

    // ------------------------------------------------------------------------
    // Remaining outputs are purely combinational from state, no added latency.
    // ------------------------------------------------------------------------
    assign digit_en    = deadTime ? 4'b1111 : ~(4'b0001 << idx_q);
    assign frame_start = (idx_q == 2'd0) && (presc_q == '0);
    assign load_ready  = !pending_q;

endmodule
